trigger_unit_seg: RTL

Parametrised next-generation capture trigger for the ADC path. It selects an ADC window comparator or a masked combination of several external trigger lines. It applies a programmable offset and issues one capture_go_o per segment over a programmable number of segments, with holdoff between segments. It sits between the register block and the sample FIFO, in the same place as the single-segment trigger unit.

---
 rtl/trigger_unit_seg_if.sv | 50 +++++
 rtl/trigger_unit_seg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/trigger_unit_seg_if.sv
// Register-block / FIFO side bundle for the segmented capture trigger.
// The parameters must match those given to trigger_unit_seg.
interface trigger_unit_seg_if #(
    parameter int ADC_W   = 12,
    parameter int NUM_EXT = 4,
    parameter int CNT_W   = 32,
    parameter int SEG_W   = 16
);
    logic [ADC_W-1:0]   adc_data;
    logic [NUM_EXT-1:0] ext_trigger_i;
    logic [NUM_EXT-1:0] ext_mask_i;
    logic               ext_and_i;
    logic               trigger_source_i;
    logic [1:0]         adc_mode_i;
    logic [ADC_W-1:0]   adc_level_lo_i;
    logic [ADC_W-1:0]   adc_level_hi_i;
    logic               trigger_level_i;
    logic               trigger_wait_i;
    logic               trigger_now_i;
    logic               arm_i;
    logic [CNT_W-1:0]   trigger_offset_i;
    logic [CNT_W-1:0]   holdoff_i;
    logic [SEG_W-1:0]   num_segments_i;
    logic               capture_done_i;
    logic               arm_o;
    logic               capture_active_o;
    logic               capture_go_o;
    logic [SEG_W-1:0]   segment_count_o;
    logic [CNT_W-1:0]   trigger_length_o;
    logic               done_o;
    logic [2:0]         state_o;

    modport slave (
        input  adc_data, ext_trigger_i, ext_mask_i, ext_and_i, trigger_source_i,
               adc_mode_i, adc_level_lo_i, adc_level_hi_i, trigger_level_i,
               trigger_wait_i, trigger_now_i, arm_i, trigger_offset_i, holdoff_i,
               num_segments_i, capture_done_i,
        output arm_o, capture_active_o, capture_go_o, segment_count_o,
               trigger_length_o, done_o, state_o
    );

    modport master (
        output adc_data, ext_trigger_i, ext_mask_i, ext_and_i, trigger_source_i,
               adc_mode_i, adc_level_lo_i, adc_level_hi_i, trigger_level_i,
               trigger_wait_i, trigger_now_i, arm_i, trigger_offset_i, holdoff_i,
               num_segments_i, capture_done_i,
        input  arm_o, capture_active_o, capture_go_o, segment_count_o,
               trigger_length_o, done_o, state_o
    );
endinterface

// File: rtl/trigger_unit_seg.sv
// Segmented capture trigger: picks an ADC window comparator or a masked
// combination of external lines, waits a programmable offset after each
// trigger and issues one capture_go pulse per segment, with holdoff between
// segments. Parameters must match those of the connected interface.
module trigger_unit_seg #(
    parameter int ADC_W   = 12,
    parameter int NUM_EXT = 4,
    parameter int CNT_W   = 32,
    parameter int SEG_W   = 16
) (
    input  logic         adc_clk,
    input  logic         reset,
    trigger_unit_seg_if.slave bus
);

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_WAIT_INACTIVE = 3'd1;
    localparam logic [2:0] S_ARMED         = 3'd2;
    localparam logic [2:0] S_DELAY         = 3'd3;
    localparam logic [2:0] S_CAPTURE       = 3'd4;
    localparam logic [2:0] S_HOLDOFF       = 3'd5;
    localparam logic [2:0] S_DONE          = 3'd6;

    logic [2:0]         r_state;
    logic               r_raw;
    logic               r_armD;
    logic               r_nowS1;
    logic               r_nowS2;
    logic               r_nowS3;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_length;
    logic [SEG_W-1:0]   r_segCount;
    logic               r_active;
    logic               r_go;
    logic               r_done;

    logic [NUM_EXT-1:0] w_extMasked;
    logic               w_extRaw;
    logic               w_adcRaw;
    logic               w_raw;
    logic               w_trigAct;
    logic               w_nowP;
    logic               w_armRise;
    logic               w_runActive;
    logic               w_abort;
    logic               w_startSeg;
    logic [SEG_W-1:0]   w_effSegs;
    logic [SEG_W-1:0]   w_segNext;

    // Raw trigger source selection: masked AND/OR of external lines or ADC window compare
    always_comb begin
        w_extMasked = bus.ext_trigger_i & bus.ext_mask_i;
        if (bus.ext_and_i) begin
            w_extRaw = (bus.ext_mask_i != '0) && (w_extMasked == bus.ext_mask_i);
        end else begin
            w_extRaw = |w_extMasked;
        end
        case (bus.adc_mode_i)
            2'b00:   w_adcRaw = bus.adc_data > bus.adc_level_hi_i;
            2'b01:   w_adcRaw = bus.adc_data < bus.adc_level_lo_i;
            2'b10:   w_adcRaw = (bus.adc_data >= bus.adc_level_lo_i) &&
                                (bus.adc_data <= bus.adc_level_hi_i);
            default: w_adcRaw = (bus.adc_data < bus.adc_level_lo_i) ||
                                (bus.adc_data > bus.adc_level_hi_i);
        endcase
        w_raw = bus.trigger_source_i ? w_adcRaw : w_extRaw;
    end

    assign w_trigAct   = (r_raw == bus.trigger_level_i);
    assign w_nowP      = r_nowS2 & ~r_nowS3;
    assign w_armRise   = bus.arm_i & ~r_armD;
    assign w_runActive = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_abort     = w_runActive & ~bus.arm_i;
    assign w_effSegs   = (bus.num_segments_i == '0) ? SEG_W'(1) : bus.num_segments_i;
    assign w_segNext   = r_segCount + SEG_W'(1);
    assign w_startSeg  = ((r_state == S_WAIT_INACTIVE) && w_nowP) ||
                         ((r_state == S_ARMED) && (w_trigAct || w_nowP));

    // Input registers: raw trigger, arm edge history and force-trigger synchroniser
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            r_raw   <= 1'b0;
            r_armD  <= 1'b0;
            r_nowS1 <= 1'b0;
            r_nowS2 <= 1'b0;
            r_nowS3 <= 1'b0;
        end else begin
            r_raw   <= w_raw;
            r_armD  <= bus.arm_i;
            r_nowS1 <= bus.trigger_now_i;
            r_nowS2 <= r_nowS1;
            r_nowS3 <= r_nowS2;
        end
    end

    // Segment sequencer; a zero offset skips DELAY so capture_go lands one cycle after the trigger
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_segCount <= '0;
            r_active   <= 1'b0;
            r_go       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_go <= 1'b0;
            if (w_abort) begin
                r_state  <= S_IDLE;
                r_active <= 1'b0;
            end else if (w_startSeg) begin
                if (bus.trigger_offset_i == '0) begin
                    r_state  <= S_CAPTURE;
                    r_go     <= 1'b1;
                    r_active <= 1'b1;
                end else begin
                    r_state <= S_DELAY;
                    r_cnt   <= CNT_W'(1);
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_armRise) begin
                            r_segCount <= '0;
                            r_done     <= 1'b0;
                            r_state    <= bus.trigger_wait_i ? S_WAIT_INACTIVE : S_ARMED;
                        end
                    end
                    S_WAIT_INACTIVE: begin
                        if (!w_trigAct) begin
                            r_state <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        r_state <= S_ARMED;
                    end
                    S_DELAY: begin
                        if (r_cnt == bus.trigger_offset_i) begin
                            r_state  <= S_CAPTURE;
                            r_go     <= 1'b1;
                            r_active <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_CAPTURE: begin
                        if (bus.capture_done_i) begin
                            r_active   <= 1'b0;
                            r_segCount <= w_segNext;
                            if (w_segNext == w_effSegs) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_HOLDOFF;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    S_HOLDOFF: begin
                        if ((bus.holdoff_i == '0) || (r_cnt == bus.holdoff_i)) begin
                            r_state <= bus.trigger_wait_i ? S_WAIT_INACTIVE : S_ARMED;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (!bus.arm_i) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating count of cycles with the trigger active during a run
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            r_length <= '0;
        end else if ((r_state == S_IDLE) && w_armRise) begin
            r_length <= '0;
        end else if (w_trigAct && (r_state != S_IDLE) && (r_length != '1)) begin
            r_length <= r_length + CNT_W'(1);
        end
    end

    assign bus.arm_o            = w_runActive;
    assign bus.capture_active_o = r_active;
    assign bus.capture_go_o     = r_go;
    assign bus.segment_count_o  = r_segCount;
    assign bus.trigger_length_o = r_length;
    assign bus.done_o           = r_done;
    assign bus.state_o          = r_state;

endmodule
